// File: rtl/uart_frame_parser_if.sv
// rtl/uart_frame_parser_if.sv - byte input and frame output bundle for uart_frame_parser
interface uart_frame_parser_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int MAX_PAYLOAD = 16
);
  localparam int LEN_W  = $clog2(MAX_PAYLOAD + 1);
  localparam int ADDR_W = $clog2(MAX_PAYLOAD);

  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [DATA_WIDTH-1:0] frm_cmd;
  logic [LEN_W-1:0]      frm_len;
  logic [ADDR_W-1:0]     frm_rd_addr;
  logic [DATA_WIDTH-1:0] frm_rd_data;
  logic                  frm_valid;
  logic                  frm_ack;
  logic                  frm_err;
  logic [1:0]            err_code;

  modport master (
    output rx_data, rx_valid, frm_rd_addr, frm_ack,
    input  rx_ready, frm_cmd, frm_len, frm_rd_data, frm_valid, frm_err, err_code
  );

  modport slave (
    input  rx_data, rx_valid, frm_rd_addr, frm_ack,
    output rx_ready, frm_cmd, frm_len, frm_rd_data, frm_valid, frm_err, err_code
  );
endinterface

// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - parses SYNC/CMD/LEN/payload/XOR-checksum frames from a byte stream
// and holds each good frame until the consumer acknowledges it.
module uart_frame_parser #(
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    MAX_PAYLOAD    = 16,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE      = 8'hA5,
  parameter int                    TIMEOUT_CYCLES = 100_000
) (
  input logic                clk,
  input logic                rstn,
  uart_frame_parser_if.slave bus
);
  localparam int LEN_W  = $clog2(MAX_PAYLOAD + 1);
  localparam int ADDR_W = $clog2(MAX_PAYLOAD);
  localparam int GAP_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [GAP_W-1:0]      GAP_LAST    = GAP_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] MAX_LEN     = DATA_WIDTH'(MAX_PAYLOAD);
  localparam logic [1:0]            ERR_CHK     = 2'b01;
  localparam logic [1:0]            ERR_LEN     = 2'b10;
  localparam logic [1:0]            ERR_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {IDLE, CMD, LEN, PAYLOAD, CHK, HOLD} state_t;

  state_t                state_q;
  state_t                state_d;
  logic [GAP_W-1:0]      gap_q;
  logic [DATA_WIDTH-1:0] xor_q;
  logic [DATA_WIDTH-1:0] cmd_q;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] frm_cmd_q;
  logic [LEN_W-1:0]      frm_len_q;
  logic                  frm_err_q;
  logic [1:0]            err_code_q;
  logic [DATA_WIDTH-1:0] buf_mem [MAX_PAYLOAD];

  logic       ready;
  logic       accept;
  logic       in_frame;
  logic       timeout_hit;
  logic       ld_cmd;
  logic       ld_len;
  logic       wr_pay;
  logic       commit;
  logic       err_det;
  logic [1:0] err_code_d;

  assign ready       = (state_q != HOLD);
  assign accept      = bus.rx_valid && ready;
  assign in_frame    = (state_q == CMD) || (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CHK);
  // An accepted byte always beats a timeout that would expire in the same cycle.
  assign timeout_hit = in_frame && !accept && (gap_q == GAP_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ld_cmd     = 1'b0;
    ld_len     = 1'b0;
    wr_pay     = 1'b0;
    commit     = 1'b0;
    err_det    = 1'b0;
    err_code_d = 2'b00;
    case (state_q)
      IDLE: begin
        if (accept && (bus.rx_data == SYNC_BYTE)) begin
          state_d = CMD;
        end
      end
      CMD: begin
        if (accept) begin
          ld_cmd  = 1'b1;
          state_d = LEN;
        end
      end
      LEN: begin
        if (accept) begin
          if (bus.rx_data > MAX_LEN) begin
            err_det    = 1'b1;
            err_code_d = ERR_LEN;
            state_d    = IDLE;
          end else begin
            ld_len  = 1'b1;
            state_d = (bus.rx_data == '0) ? CHK : PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (accept) begin
          wr_pay = 1'b1;
          if (idx_q == len_q - LEN_W'(1)) begin
            state_d = CHK;
          end
        end
      end
      CHK: begin
        if (accept) begin
          if (bus.rx_data == xor_q) begin
            commit  = 1'b1;
            state_d = HOLD;
          end else begin
            err_det    = 1'b1;
            err_code_d = ERR_CHK;
            state_d    = IDLE;
          end
        end
      end
      HOLD: begin
        if (bus.frm_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (timeout_hit) begin
      err_det    = 1'b1;
      err_code_d = ERR_TIMEOUT;
      state_d    = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gap_q      <= '0;
      xor_q      <= '0;
      cmd_q      <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      frm_cmd_q  <= '0;
      frm_len_q  <= '0;
      frm_err_q  <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      frm_err_q <= err_det;
      if (err_det) begin
        err_code_q <= err_code_d;
      end
      if (accept || timeout_hit || !in_frame) begin
        gap_q <= '0;
      end else begin
        gap_q <= gap_q + GAP_W'(1);
      end
      if (ld_cmd) begin
        cmd_q <= bus.rx_data;
        xor_q <= bus.rx_data;
      end
      if (ld_len) begin
        len_q <= bus.rx_data[LEN_W-1:0];
        idx_q <= '0;
        xor_q <= xor_q ^ bus.rx_data;
      end
      if (wr_pay) begin
        idx_q <= idx_q + LEN_W'(1);
        xor_q <= xor_q ^ bus.rx_data;
      end
      // Published frame fields only change on a fully verified frame.
      if (commit) begin
        frm_cmd_q <= cmd_q;
        frm_len_q <= len_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_pay) begin
      buf_mem[idx_q[ADDR_W-1:0]] <= bus.rx_data;
    end
  end

  assign bus.rx_ready    = ready;
  assign bus.frm_valid   = (state_q == HOLD);
  assign bus.frm_cmd     = frm_cmd_q;
  assign bus.frm_len     = frm_len_q;
  assign bus.frm_err     = frm_err_q;
  assign bus.err_code    = err_code_q;
  assign bus.frm_rd_data = buf_mem[bus.frm_rd_addr];
endmodule

// File: tb/tb_uart_frame_parser.sv
// tb/tb_uart_frame_parser.sv - directed frames checked against a frame-level reference model
module tb_uart_frame_parser;
  localparam int DW   = 8;
  localparam int MAXP = 16;
  localparam int TO   = 20;
  localparam int AW   = $clog2(MAXP);

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  uart_frame_parser_if #(.DATA_WIDTH(DW), .MAX_PAYLOAD(MAXP)) bus ();

  uart_frame_parser #(
    .DATA_WIDTH(DW), .MAX_PAYLOAD(MAXP), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model state: bytes of the frame being collected, idle edges since last byte.
  logic [7:0] cur[$];
  int         idle_cnt  = 0;
  bit         exp_valid = 0;
  bit         exp_err   = 0;
  int         exp_code  = 0;
  int         exp_cmd   = 0;
  int         exp_len   = 0;
  logic [7:0] pay [MAXP];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic raise_err(input int code);
    exp_err  = 1;
    exp_code = code;
  endtask

  task automatic feed(input logic [7:0] b);
    logic [7:0] x;
    idle_cnt = 0;
    if (cur.size() == 0) begin
      if (b == 8'hA5) cur.push_back(b);
    end else begin
      cur.push_back(b);
      if (cur.size() == 3 && int'(b) > MAXP) begin
        raise_err(2);
        cur.delete();
      end else if (cur.size() >= 3 && cur.size() == int'(cur[2]) + 4) begin
        x = 8'h00;
        for (int i = 1; i < cur.size() - 1; i++) x ^= cur[i];
        if (x == b) begin
          exp_valid = 1;
          exp_cmd   = cur[1];
          exp_len   = cur[2];
          for (int i = 0; i < int'(cur[2]); i++) pay[i] = cur[3 + i];
        end else begin
          raise_err(1);
        end
        cur.delete();
      end
    end
  endtask

  initial begin : compare_proc
    logic       v;
    logic       a;
    logic [7:0] d;
    forever begin
      @(posedge clk);
      v = bus.rx_valid;
      d = bus.rx_data;
      a = bus.frm_ack;
      exp_err = 0;
      if (!rstn) begin
        cur.delete();
        idle_cnt  = 0;
        exp_valid = 0;
        exp_code  = 0;
        exp_cmd   = 0;
        exp_len   = 0;
      end else if (exp_valid) begin
        if (a) exp_valid = 0;
      end else if (v) begin
        feed(d);
      end else if (cur.size() != 0) begin
        idle_cnt++;
        if (idle_cnt >= TO) begin
          raise_err(3);
          cur.delete();
        end
      end
      #1;
      chk("rx_ready", bus.rx_ready, !exp_valid);
      chk("frm_valid", bus.frm_valid, exp_valid);
      chk("frm_err", bus.frm_err, exp_err);
      chk("err_code", bus.err_code, exp_code);
      chk("frm_cmd", bus.frm_cmd, exp_cmd);
      chk("frm_len", bus.frm_len, exp_len);
      if (exp_valid && int'(bus.frm_rd_addr) < exp_len)
        chk("frm_rd_data", bus.frm_rd_data, pay[bus.frm_rd_addr]);
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
    end
  endtask

  task automatic ack();
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.frm_ack  = 1'b1;
    @(negedge clk);
    bus.frm_ack  = 1'b0;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    int  waited;
    bit  seen;
    bus.rx_valid    = 1'b0;
    bus.rx_data     = 8'h00;
    bus.frm_ack     = 1'b0;
    bus.frm_rd_addr = '0;
    idle(2);
    chk("rst_ready", bus.rx_ready, 1);
    chk("rst_valid", bus.frm_valid, 0);
    chk("rst_err_code", bus.err_code, 0);
    chk("rst_cmd", bus.frm_cmd, 0);
    rstn = 1'b1;
    idle(2);

    // ack outside HOLD is ignored, then the basic good frame
    ack();
    send(8'hA5); send(8'h10); send(8'h02); send(8'h01); send(8'h02); send(8'h11);
    chk("good_valid_early", bus.frm_valid, 0);
    idle(1);
    chk("good_valid", bus.frm_valid, 1);
    chk("good_cmd", bus.frm_cmd, 8'h10);
    chk("good_len", bus.frm_len, 2);
    chk("good_ready", bus.rx_ready, 0);
    bus.frm_rd_addr = AW'(0);
    #1 chk("good_addr0", bus.frm_rd_data, 8'h01);
    bus.frm_rd_addr = AW'(1);
    #1 chk("good_addr1", bus.frm_rd_data, 8'h02);
    idle(2);
    ack();
    chk("ack_valid", bus.frm_valid, 0);
    chk("ack_ready", bus.rx_ready, 1);

    // bad checksum, then a good frame 33 01 44 (chk 76)
    send(8'hA5); send(8'h10); send(8'h02); send(8'h01); send(8'h02); send(8'h00);
    idle(1);
    chk("chk_err_pulse", bus.frm_err, 1);
    chk("chk_err_code", bus.err_code, 1);
    chk("chk_valid", bus.frm_valid, 0);
    chk("chk_cmd_kept", bus.frm_cmd, 8'h10);
    idle(1);
    chk("chk_err_once", bus.frm_err, 0);
    send(8'hA5); send(8'h33); send(8'h01); send(8'h44); send(8'h76);
    bus.frm_rd_addr = AW'(0);
    idle(1);
    chk("after_err_valid", bus.frm_valid, 1);
    chk("after_err_addr0", bus.frm_rd_data, 8'h44);
    ack();

    // length 17 exceeds the buffer; trailing 00 is discarded in IDLE
    send(8'hA5); send(8'h10); send(8'h11);
    idle(1);
    chk("len_err_pulse", bus.frm_err, 1);
    chk("len_err_code", bus.err_code, 2);
    send(8'h00);
    send(8'hA5); send(8'h55); send(8'h00); send(8'h55);
    idle(1);
    chk("len_next_valid", bus.frm_valid, 1);
    chk("len_next_cmd", bus.frm_cmd, 8'h55);
    ack();

    // inter-byte timeout
    send(8'hA5); send(8'h10);
    seen = 0;
    waited = 0;
    while (!seen && waited < 3 * TO) begin
      idle(1);
      waited++;
      if (bus.frm_err) seen = 1;
    end
    chk("timeout_seen", seen, 1);
    chk("timeout_latency", waited, TO + 1);
    chk("timeout_code", bus.err_code, 3);

    // byte on the expiry cycle wins
    send(8'hA5); send(8'h10);
    idle(TO - 1);
    send(8'h00);
    send(8'h10);
    idle(1);
    chk("expiry_no_err", bus.frm_err, 0);
    chk("expiry_valid", bus.frm_valid, 1);
    chk("expiry_len", bus.frm_len, 0);
    ack();

    // leading garbage, zero-length frame, bytes dropped in HOLD
    send(8'h00); send(8'hFF); send(8'hA5); send(8'h20); send(8'h00); send(8'h20);
    idle(1);
    chk("zl_valid", bus.frm_valid, 1);
    chk("zl_cmd", bus.frm_cmd, 8'h20);
    chk("zl_len", bus.frm_len, 0);
    send(8'hA5); send(8'h77); send(8'h00);
    idle(1);
    chk("hold_drop_valid", bus.frm_valid, 1);
    chk("hold_drop_cmd", bus.frm_cmd, 8'h20);
    ack();
    send(8'h77); send(8'h00); send(8'h77);
    idle(1);
    chk("hold_drop_idle", bus.frm_valid, 0);

    // reset mid-frame, then frame 42 03 01 02 03 (chk 41)
    send(8'hA5); send(8'h10); send(8'h01);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    rstn = 1'b0;
    #1;
    chk("midrst_cmd", bus.frm_cmd, 0);
    chk("midrst_len", bus.frm_len, 0);
    chk("midrst_code", bus.err_code, 0);
    chk("midrst_err", bus.frm_err, 0);
    chk("midrst_ready", bus.rx_ready, 1);
    idle(2);
    rstn = 1'b1;
    send(8'hA5); send(8'h42); send(8'h03); send(8'h01); send(8'h02); send(8'h03); send(8'h41);
    bus.frm_rd_addr = AW'(2);
    idle(1);
    chk("post_rst_valid", bus.frm_valid, 1);
    chk("post_rst_cmd", bus.frm_cmd, 8'h42);
    chk("post_rst_len", bus.frm_len, 3);
    chk("post_rst_addr2", bus.frm_rd_data, 8'h03);
    ack();
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_frame_parser.md
UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 Parameter DATA_WIDTH, default 8: byte width of rx_data and all frame fields.
REQ-002 Parameter MAX_PAYLOAD, default 16: payload buffer depth in bytes.
REQ-003 Parameter SYNC_BYTE, default 8'hA5: frame start marker.
REQ-004 Parameter TIMEOUT_CYCLES, default 100_000: maximum idle gap between bytes inside a frame (1 ms at 100 MHz).
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 rstn  input  1  reset; one clock, reset asynchronous and active-low.
REQ-007 rx_data  input  DATA_WIDTH  received byte from the UART receiver.
REQ-008 rx_valid  input  1  single-cycle strobe; rx_data is valid this cycle.
REQ-009 rx_ready  output  1  parser can accept a byte; drives the receiver's downstream-ready input.
REQ-010 frm_cmd  output  DATA_WIDTH  command byte of the last good frame.
REQ-011 frm_len  output  $clog2(MAX_PAYLOAD+1)  payload length of the last good frame.
REQ-012 frm_rd_addr  input  $clog2(MAX_PAYLOAD)  payload buffer read address.
REQ-013 frm_rd_data  output  DATA_WIDTH  payload byte at frm_rd_addr, combinational read.
REQ-014 frm_valid  output  1  level; good frame available.
REQ-015 frm_ack  input  1  consumer releases the frame.
REQ-016 frm_err  output  1  single-cycle error pulse.
REQ-017 err_code  output  2  last error: 01 checksum, 10 length, 11 timeout.

Function
REQ-018 Frame format SHALL be SYNC_BYTE, CMD, LEN, LEN payload bytes, CHK, where CHK = XOR of CMD, LEN and all payload bytes.
REQ-019 A byte SHALL be accepted only in a cycle with rx_valid=1 and rx_ready=1; rx_valid while rx_ready=0 SHALL be dropped with no state change.
REQ-020 FSM states SHALL be IDLE, CMD, LEN, PAYLOAD, CHK, HOLD.
REQ-021 IDLE: byte == SYNC_BYTE -> CMD; any other byte discarded silently, stay in IDLE, no error.
REQ-022 CMD: store byte, seed running XOR with it -> LEN.
REQ-023 LEN: LEN > MAX_PAYLOAD -> err_code 10, frm_err pulse, -> IDLE; LEN == 0 -> CHK; otherwise -> PAYLOAD.
REQ-024 PAYLOAD: write byte to buffer at index 0..LEN-1 in order, fold into XOR; after byte LEN-1 -> CHK.
REQ-025 CHK: byte == running XOR -> HOLD; mismatch -> err_code 01, frm_err pulse, -> IDLE.
REQ-026 frm_valid SHALL assert the cycle after the matching CHK byte is accepted, with frm_cmd and frm_len updated in the same cycle.
REQ-027 HOLD: rx_ready=0, frm_valid=1, outputs and buffer stable; frm_ack=1 -> IDLE, with frm_valid=0 and rx_ready=1 the next cycle.
REQ-028 rx_ready SHALL be 1 in every state except HOLD.
REQ-029 frm_ack outside HOLD SHALL be ignored.
REQ-030 Gap counter SHALL clear on every accepted byte and count in CMD, LEN, PAYLOAD and CHK; reaching TIMEOUT_CYCLES -> err_code 11, frm_err pulse, -> IDLE.
REQ-031 Gap counter SHALL NOT count in IDLE or HOLD.
REQ-032 Byte accepted in the same cycle the counter expires: the byte SHALL win and no timeout SHALL occur.
REQ-033 frm_err SHALL pulse exactly one cycle, the cycle after detection; err_code SHALL update in that same cycle and hold until the next error.
REQ-034 frm_rd_data for addresses >= frm_len, or while frm_valid=0, SHALL be unspecified.
REQ-035 A partial frame SHALL never modify frm_cmd or frm_len.

Reset
REQ-036 rstn=0 SHALL immediately force state IDLE, gap counter 0, running XOR 0, rx_ready=1, frm_valid=0, frm_err=0, err_code=00, frm_cmd=0, frm_len=0.
REQ-037 Buffer contents SHALL NOT require reset.
REQ-038 Reset asserted mid-frame or in HOLD SHALL abandon the frame with no frm_err pulse.

Verification
REQ-039 Feed A5 10 02 01 02 11 -> frm_valid=1 one cycle after the last byte, frm_cmd=10, frm_len=2, addr0=01, addr1=02; frm_ack -> frm_valid=0, rx_ready=1.
REQ-040 Feed A5 10 02 01 02 00 -> one-cycle frm_err pulse, err_code=01, frm_valid stays 0, next good frame is accepted.
REQ-041 Feed A5 10 11 (LEN=17 > 16) -> frm_err after the LEN byte, err_code=10; the following 00 byte is ignored in IDLE.
REQ-042 Feed A5 10, then idle 100_000 cycles -> frm_err, err_code=11; byte arriving on the expiry cycle -> no error.
REQ-043 Feed 00 FF A5 20 00 20 -> no frm_err; frm_valid with frm_cmd=20, frm_len=0; rx_valid during HOLD is dropped.
REQ-044 Pull rstn low after A5 10 01 -> outputs return to reset values at once, no frm_err; the next full frame is parsed correctly.
